// File: rtl/tag_assoc.sv
// N-way set-associative tag array with registered compare, dirty tracking,
// line fills and a one-set-per-cycle invalidate sweep.
module tag_assoc #(
  parameter int NL   = 512,
  parameter int LSS  = 9,
  parameter int WAYS = 2,
  parameter int WS   = 1,
  parameter int AW   = 32,
  parameter int PSL  = LSS + 5,
  parameter int TW   = AW - PSL
) (
  input  logic          nGCLK,
  input  logic          reset,
  input  logic          lk_valid,
  input  logic [AW-1:0] lk_addr,
  input  logic          lk_write,
  output logic          rsp_valid,
  output logic          hit,
  output logic [WS-1:0] hit_way,
  output logic [WS-1:0] victim_way,
  output logic          victim_dirty,
  output logic [TW-1:0] victim_tag,
  input  logic          fill_ena,
  input  logic [AW-1:0] fill_addr,
  input  logic [WS-1:0] fill_way,
  input  logic          fill_dirty,
  input  logic          inv_all,
  output logic          busy
);

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [LSS-1:0]  cnt_q, cnt_d;

  logic [TW-1:0]   tag_mem [WAYS][NL];
  logic [WAYS-1:0] v_mem   [NL];
  logic [WAYS-1:0] d_mem   [NL];
  logic [WS-1:0]   rr_mem  [NL];

  logic [LSS-1:0]  lk_set, fill_set;
  logic [TW-1:0]   lk_tag, fill_tag;
  logic            unused_addr_bits;

  // Capture stage: request fields plus a snapshot of the addressed set.
  logic            s1_valid_q, s1_valid_d;
  logic            s1_write_q, s1_write_d;
  logic            s1_sweep_q, s1_sweep_d;
  logic [LSS-1:0]  s1_set_q, s1_set_d;
  logic [TW-1:0]   s1_tag_q, s1_tag_d;
  logic [TW-1:0]   rd_tag_q [WAYS];
  logic [TW-1:0]   rd_tag_d [WAYS];
  logic [WAYS-1:0] rd_v_q, rd_v_d;
  logic [WAYS-1:0] rd_d_q, rd_d_d;
  logic [WS-1:0]   rd_rr_q, rd_rr_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            hit_q, hit_d;
  logic [WS-1:0]   hit_way_q, hit_way_d;
  logic [WS-1:0]   victim_way_q, victim_way_d;
  logic            victim_dirty_q, victim_dirty_d;
  logic [TW-1:0]   victim_tag_q, victim_tag_d;

  logic [WAYS-1:0] hit_vec;
  logic            any_hit;
  logic [WS-1:0]   hit_way_c, victim_c;
  logic            sweep_we, fill_we, dirty_we;

  assign lk_set   = lk_addr[PSL-1:PSL-LSS];
  assign lk_tag   = lk_addr[AW-1:PSL];
  assign fill_set = fill_addr[PSL-1:PSL-LSS];
  assign fill_tag = fill_addr[AW-1:PSL];
  assign unused_addr_bits = ^{lk_addr[PSL-LSS-1:0], fill_addr[PSL-LSS-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LSS'(NL - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (inv_all) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // Compare the snapshot; lowest index wins for both hit and free-way search.
  always_comb begin
    hit_vec   = '0;
    hit_way_c = '0;
    victim_c  = rd_rr_q;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = rd_v_q[w] && (rd_tag_q[w] == s1_tag_q);
      if (hit_vec[w]) hit_way_c = WS'(w);
      if (!rd_v_q[w]) victim_c = WS'(w);
    end
    any_hit = (|hit_vec) && !s1_sweep_q;
  end

  // A sweep starting on this edge clears every set anyway, so a dirty update
  // racing it can be dropped.
  assign sweep_we = (state_q == SWEEP) && !reset;
  assign fill_we  = fill_ena && (state_q == IDLE) && !reset;
  assign dirty_we = s1_valid_q && s1_write_q && any_hit &&
                    (state_q == IDLE) && !inv_all && !reset;

  always_comb begin
    s1_valid_d = lk_valid;
    s1_write_d = lk_write;
    s1_sweep_d = (state_q == SWEEP);
    s1_set_d   = lk_set;
    s1_tag_d   = lk_tag;
    rd_v_d     = v_mem[lk_set];
    rd_rr_d    = rr_mem[lk_set];
    rd_d_d     = d_mem[lk_set];
    for (int w = 0; w < WAYS; w++) rd_tag_d[w] = tag_mem[w][lk_set];
    // Memory is read before this edge's writes; only the D update is bypassed.
    if (dirty_we && (s1_set_q == lk_set)) rd_d_d[hit_way_c] = 1'b1;
  end

  always_comb begin
    rsp_valid_d    = s1_valid_q;
    hit_d          = 1'b0;
    hit_way_d      = '0;
    victim_way_d   = '0;
    victim_dirty_d = 1'b0;
    victim_tag_d   = '0;
    if (s1_valid_q && !s1_sweep_q) begin
      hit_d          = any_hit;
      hit_way_d      = hit_way_c;
      victim_way_d   = victim_c;
      victim_dirty_d = rd_d_q[victim_c];
      victim_tag_d   = rd_tag_q[victim_c];
    end
  end

  always_ff @(posedge nGCLK) begin
    if (sweep_we) begin
      v_mem[cnt_q]  <= '0;
      d_mem[cnt_q]  <= '0;
      rr_mem[cnt_q] <= '0;
      for (int w = 0; w < WAYS; w++) tag_mem[w][cnt_q] <= '0;
    end else begin
      if (dirty_we) d_mem[s1_set_q][hit_way_c] <= 1'b1;
      if (fill_we) begin
        tag_mem[fill_way][fill_set] <= fill_tag;
        v_mem[fill_set][fill_way]   <= 1'b1;
        d_mem[fill_set][fill_way]   <= fill_dirty;
        rr_mem[fill_set]            <= fill_way + 1'b1;
      end
    end
  end

  always_ff @(posedge nGCLK) begin
    if (reset) begin
      state_q        <= SWEEP;
      cnt_q          <= '0;
      s1_valid_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      victim_way_q   <= '0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      s1_valid_q     <= s1_valid_d;
      rsp_valid_q    <= rsp_valid_d;
      hit_q          <= hit_d;
      hit_way_q      <= hit_way_d;
      victim_way_q   <= victim_way_d;
      victim_dirty_q <= victim_dirty_d;
      victim_tag_q   <= victim_tag_d;
    end
  end

  always_ff @(posedge nGCLK) begin
    s1_write_q <= s1_write_d;
    s1_sweep_q <= s1_sweep_d;
    s1_set_q   <= s1_set_d;
    s1_tag_q   <= s1_tag_d;
    rd_v_q     <= rd_v_d;
    rd_d_q     <= rd_d_d;
    rd_rr_q    <= rd_rr_d;
    for (int w = 0; w < WAYS; w++) rd_tag_q[w] <= rd_tag_d[w];
  end

  assign rsp_valid    = rsp_valid_q;
  assign hit          = hit_q;
  assign hit_way      = hit_way_q;
  assign victim_way   = victim_way_q;
  assign victim_dirty = victim_dirty_q;
  assign victim_tag   = victim_tag_q;
  assign busy         = (state_q == SWEEP);

endmodule

// File: tb/tb_tag_assoc.sv
// Directed bench for tag_assoc: lookups push expected responses into a queue
// that a negedge monitor pops and compares when rsp_valid appears.
module tb_tag_assoc;
  localparam int NL = 512, LSS = 9, WAYS = 2, WS = 1, AW = 32;
  localparam int PSL = LSS + 5, TW = AW - PSL;

  logic          nGCLK, reset;
  logic          lk_valid, lk_write;
  logic [AW-1:0] lk_addr;
  logic          rsp_valid, hit, victim_dirty;
  logic [WS-1:0] hit_way, victim_way;
  logic [TW-1:0] victim_tag;
  logic          fill_ena, fill_dirty, inv_all, busy;
  logic [AW-1:0] fill_addr;
  logic [WS-1:0] fill_way;

  typedef struct packed {
    logic          hit;
    logic [WS-1:0] hit_way;
    logic [WS-1:0] victim_way;
    logic          victim_dirty;
    logic [TW-1:0] victim_tag;
    logic          chk_tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   n;

  tag_assoc #(.NL(NL), .LSS(LSS), .WAYS(WAYS), .WS(WS), .AW(AW)) dut (
    .nGCLK(nGCLK), .reset(reset),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_write(lk_write),
    .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .fill_ena(fill_ena), .fill_addr(fill_addr), .fill_way(fill_way),
    .fill_dirty(fill_dirty), .inv_all(inv_all), .busy(busy)
  );

  // Clock / reset
  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", name, obs, exp);
      $error("check %s failed", name);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(negedge nGCLK);
    lk_valid = 1'b0;
    lk_write = 1'b0;
    fill_ena = 1'b0;
    inv_all  = 1'b0;
  endtask

  task automatic do_lookup(input logic [AW-1:0] addr, input logic wr,
                           input logic e_hit, input logic [WS-1:0] e_hw,
                           input logic [WS-1:0] e_vw, input logic e_vd,
                           input logic [TW-1:0] e_vt, input logic e_chk);
    exp_t e;
    lk_valid = 1'b1;
    lk_addr  = addr;
    lk_write = wr;
    e.hit = e_hit; e.hit_way = e_hw; e.victim_way = e_vw;
    e.victim_dirty = e_vd; e.victim_tag = e_vt; e.chk_tag = e_chk;
    exp_q.push_back(e);
  endtask

  task automatic do_fill(input logic [AW-1:0] addr, input logic [WS-1:0] way, input logic dirty);
    fill_ena   = 1'b1;
    fill_addr  = addr;
    fill_way   = way;
    fill_dirty = dirty;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      step();
    end
  endtask

  // Scoreboard
  always @(negedge nGCLK) begin
    if (reset === 1'b0 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("hit", 32'(hit), 32'(cur.hit));
        check("hit_way", 32'(hit_way), 32'(cur.hit_way));
        check("victim_way", 32'(victim_way), 32'(cur.victim_way));
        check("victim_dirty", 32'(victim_dirty), 32'(cur.victim_dirty));
        if (cur.chk_tag) check("victim_tag", 32'(victim_tag), 32'(cur.victim_tag));
      end
    end
  end

  initial begin
    reset = 1'b1; lk_valid = 1'b0; lk_write = 1'b0; lk_addr = '0;
    fill_ena = 1'b0; fill_addr = '0; fill_way = '0; fill_dirty = 1'b0; inv_all = 1'b0;
    @(negedge nGCLK);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_way", 32'(hit_way), 32'd0);
    check("rst_victim_way", 32'(victim_way), 32'd0);
    check("rst_victim_dirty", 32'(victim_dirty), 32'd0);
    check("rst_victim_tag", 32'(victim_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;

    // Power-up sweep length, then a miss on an empty array
    count_busy(n);
    check("sweep_len_reset", 32'(n), 32'd512);
    check("busy_low", 32'(busy), 32'd0);
    do_lookup(32'h0000_4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b1); step();

    // Single fill, hit and same-set miss
    do_fill(32'h1234_5660, 1'b1, 1'b0); step();
    do_lookup(32'h1234_5660, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h0, 1'b1); step();
    do_lookup(32'h9234_5660, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b1); step();

    // Round-robin victim in set 0x133
    do_fill(32'h0004_6660, 1'b0, 1'b0); step();
    do_fill(32'h0008_A660, 1'b1, 1'b0); step();
    do_lookup(32'h000C_E660, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h11, 1'b1); step();
    do_fill(32'h0011_2660, 1'b0, 1'b1); step();
    do_lookup(32'h000C_E660, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h22, 1'b1); step();
    do_lookup(32'h0011_2660, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h22, 1'b1); step();

    // Fill and lookup of the same line in one cycle: lookup sees old contents
    do_fill(32'h001D_CA00, 1'b0, 1'b0);
    do_lookup(32'h001D_CA00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b1); step();
    do_lookup(32'h001D_CA00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h0, 1'b1); step();

    // Write hit, then back-to-back lookup needing the forwarded D bit
    do_fill(32'h0015_5660, 1'b0, 1'b0); step();
    do_lookup(32'h1234_5660, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 18'h48D1, 1'b1); step();
    do_lookup(32'h9234_5660, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h48D1, 1'b1); step();
    repeat ($urandom_range(1, 4)) step();
    do_lookup(32'h9234_5660, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h48D1, 1'b1); step();

    // Fill beats a same-edge D update to the same way
    do_lookup(32'h1234_5660, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h48D1, 1'b1); step();
    do_fill(32'h1234_5660, 1'b1, 1'b0); step();
    do_fill(32'h0015_5660, 1'b0, 1'b0); step();
    do_lookup(32'h9234_5660, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h48D1, 1'b1); step();

    // inv_all sweep; a second inv_all mid-sweep must not extend it
    inv_all = 1'b1; step();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (n == 10) do_lookup(32'h1234_5660, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b0);
      if (n == 50) inv_all = 1'b1;
      n++;
      step();
    end
    check("sweep_len_inv", 32'(n), 32'd512);
    do_lookup(32'h1234_5660, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b1); step();
    do_lookup(32'h0011_2660, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b1); step();

    // Reset at sweep cycle 100 restarts it; fills during the sweep are dropped
    inv_all = 1'b1; step();
    repeat (100) step();
    check("busy_mid_sweep", 32'(busy), 32'd1);
    reset = 1'b1; step();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (n == 200) do_fill(32'h0026_4200, 1'b0, 1'b0);
      n++;
      step();
    end
    check("sweep_len_restart", 32'(n), 32'd512);
    do_lookup(32'h0026_4200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1'b1); step();

    repeat (4) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
